// File: rtl/immediate_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | immediate_pkg : immediate format encodings shared by the stage |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
package immediate_pkg;

  localparam int IMM_W = 3;

  typedef enum logic [IMM_W-1:0] {
    IMM_I  = 3'd0,
    IMM_S  = 3'd1,
    IMM_B  = 3'd2,
    IMM_U  = 3'd3,
    IMM_J  = 3'd4,
    IMM_Z  = 3'd5,
    IMM_SH = 3'd6
  } immediate_e;

endpackage
`default_nettype wire

// File: rtl/immediate_extract.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | immediate_extract : combinational immediate format mux          |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
module immediate_extract
  import immediate_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]      instruction,
  input  logic [IMM_W-1:0] imm_type,
  output logic [XLEN-1:0]  immediate
);

  logic [31:0] sext_val;
  logic [5:0]  zext_val;
  logic        use_zext;

  always_comb begin
    sext_val = '0;
    zext_val = '0;
    use_zext = 1'b0;
    case (imm_type)
      IMM_S:  sext_val = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
      IMM_B:  sext_val = {{19{instruction[31]}}, instruction[31], instruction[7],
                          instruction[30:25], instruction[11:8], 1'b0};
      IMM_U:  sext_val = {instruction[31:12], 12'h000};
      IMM_J:  sext_val = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                          instruction[20], instruction[30:21], 1'b0};
      IMM_Z: begin
        use_zext = 1'b1;
        zext_val = {1'b0, instruction[19:15]};
      end
      IMM_SH: begin
        use_zext = 1'b1;
        // RV64 shift amounts carry one more bit than RV32
        zext_val = (XLEN == 64) ? instruction[25:20] : {1'b0, instruction[24:20]};
      end
      default: sext_val = {{20{instruction[31]}}, instruction[31:20]};
    endcase
  end

  assign immediate = use_zext ? XLEN'(zext_val) : XLEN'($signed(sext_val));

endmodule
`default_nettype wire

// File: rtl/immediate_stage.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | immediate_stage : registered immediate generator, 2-entry skid  |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
module immediate_stage
  import immediate_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [31:0]      instruction_i,
  input  logic [IMM_W-1:0] type_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [XLEN-1:0]  immediate_o,
  output logic [TAG_W-1:0] tag_o
);

  if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
    $error("immediate_stage: XLEN must be 32 or 64");
  end
  if (TAG_W < 1) begin : g_bad_tag
    $error("immediate_stage: TAG_W must be at least 1");
  end

  logic [XLEN-1:0]  new_imm;
  logic             out_full;
  logic             skid_free;
  logic [XLEN-1:0]  skid_imm;
  logic [TAG_W-1:0] skid_tag;
  logic             in_fire;
  logic             out_open;

  immediate_extract #(.XLEN(XLEN)) u_extract (
    .instruction (instruction_i),
    .imm_type    (type_i),
    .immediate   (new_imm)
  );

  // Ready is a flop of its own so it never sees out_ready_i combinationally
  assign in_ready_o  = skid_free;
  assign out_valid_o = out_full;
  assign in_fire     = in_valid_i & skid_free;
  assign out_open    = ~out_full | out_ready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_full    <= 1'b0;
      skid_free   <= 1'b1;
      immediate_o <= '0;
      tag_o       <= '0;
      skid_imm    <= '0;
      skid_tag    <= '0;
    end else if (flush_i) begin
      out_full  <= 1'b0;
      skid_free <= 1'b1;
    end else if (out_open) begin
      if (!skid_free) begin
        immediate_o <= skid_imm;
        tag_o       <= skid_tag;
        out_full    <= 1'b1;
        skid_free   <= 1'b1;
      end else if (in_fire) begin
        immediate_o <= new_imm;
        tag_o       <= tag_i;
        out_full    <= 1'b1;
      end else begin
        out_full <= 1'b0;
      end
    end else if (in_fire) begin
      skid_imm  <= new_imm;
      skid_tag  <= tag_i;
      skid_free <= 1'b0;
    end
  end

endmodule
`default_nettype wire
